// File: rtl/fft8_stream_cplx.sv
// fft8_stream_cplx: 8-point radix-2 DIT FFT/IFFT on complex frames, three register
// stages sharing one advance signal, optional per-stage halving, clamped outputs.
module fft8_stream_cplx #(
  parameter int IN_W  = 8,
  parameter int TW_W  = 16,
  parameter int OUT_W = 16,
  parameter int SCALE = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_inverse,
  input  logic [8*IN_W-1:0]  s_re,
  input  logic [8*IN_W-1:0]  s_im,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_inverse,
  output logic               m_ovf,
  output logic [8*OUT_W-1:0] m_re,
  output logic [8*OUT_W-1:0] m_im
);
  localparam int W1 = IN_W + 1;
  localparam int W2 = IN_W + 2;
  localparam int W3 = IN_W + 4;
  localparam int PW = W2 + TW_W + 1;
  localparam int SW = (OUT_W > W3) ? OUT_W : W3;
  localparam int C  = $rtoi($floor(2.0 ** (TW_W - 1) / $sqrt(2.0) + 0.5));
  localparam logic signed [PW-1:0] CP  = PW'(C);
  localparam logic signed [PW-1:0] RND = {{(PW-TW_W+1){1'b0}}, 1'b1, {(TW_W-2){1'b0}}};
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic                     adv;
  logic                     v1_q, v2_q, v3_q, inv1_q, inv2_q, inv3_q, ovf_q, ovf_d;
  logic signed [IN_W-1:0]   x_re[8], x_im[8];
  logic signed [W1-1:0]     s1_re_d[8], s1_im_d[8], s1_re_q[8], s1_im_q[8];
  logic signed [W2-1:0]     s2_re_d[8], s2_im_d[8], s2_re_q[8], s2_im_q[8];
  logic [8*OUT_W-1:0]       re_d, im_d, re_q, im_q;

  function automatic logic signed [W1-1:0] half1(input logic signed [W1-1:0] v);
    return (SCALE != 0) ? (v >>> 1) : v;
  endfunction

  function automatic logic signed [W2-1:0] half2(input logic signed [W2-1:0] v);
    return (SCALE != 0) ? (v >>> 1) : v;
  endfunction

  function automatic logic signed [W3-1:0] half3(input logic signed [W3-1:0] v);
    return (SCALE != 0) ? (v >>> 1) : v;
  endfunction

  // Returns {clamped, value}; with OUT_W >= W3 the bounds are never reached.
  function automatic logic [OUT_W:0] clamp(input logic signed [W3-1:0] v);
    logic signed [SW-1:0] w;
    w = SW'(v);
    if (w > SAT_MAX) return {1'b1, SAT_MAX[OUT_W-1:0]};
    if (w < SAT_MIN) return {1'b1, SAT_MIN[OUT_W-1:0]};
    return {1'b0, w[OUT_W-1:0]};
  endfunction

  assign adv       = ~v3_q | m_ready;
  assign s_ready   = adv;
  assign m_valid   = v3_q;
  assign m_inverse = inv3_q;
  assign m_ovf     = ovf_q;
  assign m_re      = re_q;
  assign m_im      = im_q;

  always_comb begin
    for (int unsigned n = 0; n < 8; n++) begin
      x_re[n] = s_re[n*IN_W +: IN_W];
      x_im[n] = s_im[n*IN_W +: IN_W];
    end
  end

  // S1 layout: [0..3] = A_k, [4..7] = B_k
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      s1_re_d[k]   = half1(W1'(x_re[k]) + W1'(x_re[k+4]));
      s1_im_d[k]   = half1(W1'(x_im[k]) + W1'(x_im[k+4]));
      s1_re_d[k+4] = half1(W1'(x_re[k]) - W1'(x_re[k+4]));
      s1_im_d[k+4] = half1(W1'(x_im[k]) - W1'(x_im[k+4]));
    end
  end

  // S2 layout: [0..3] = E_k, [4..7] = O_k; r*B2 is a swap/negate (-j fwd, +j inv)
  always_comb begin
    logic signed [W2-1:0] a0r, a0i, a2r, a2i, b0r, b0i, rbr, rbi;
    {a0r, a0i, a2r, a2i, b0r, b0i, rbr, rbi} = '0;
    for (int unsigned h = 0; h < 2; h++) begin
      a0r = W2'(s1_re_q[h]);     a0i = W2'(s1_im_q[h]);
      a2r = W2'(s1_re_q[h+2]);   a2i = W2'(s1_im_q[h+2]);
      b0r = W2'(s1_re_q[h+4]);   b0i = W2'(s1_im_q[h+4]);
      rbr = inv1_q ? -W2'(s1_im_q[h+6]) :  W2'(s1_im_q[h+6]);
      rbi = inv1_q ?  W2'(s1_re_q[h+6]) : -W2'(s1_re_q[h+6]);
      s2_re_d[4*h]   = half2(a0r + a2r);  s2_im_d[4*h]   = half2(a0i + a2i);
      s2_re_d[4*h+2] = half2(a0r - a2r);  s2_im_d[4*h+2] = half2(a0i - a2i);
      s2_re_d[4*h+1] = half2(b0r + rbr);  s2_im_d[4*h+1] = half2(b0i + rbi);
      s2_re_d[4*h+3] = half2(b0r - rbr);  s2_im_d[4*h+3] = half2(b0i - rbi);
    end
  end

  always_comb begin
    logic signed [W2-1:0] o_r, o_i;
    logic signed [W3-1:0] e_r, e_i, t_r, t_i;
    logic signed [PW-1:0] pa, pb, p_r, p_i;
    logic [OUT_W:0]       c;
    {o_r, o_i, e_r, e_i, t_r, t_i, pa, pb, p_r, p_i, c} = '0;
    re_d  = '0;
    im_d  = '0;
    ovf_d = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      o_r = s2_re_q[k+4];
      o_i = s2_im_q[k+4];
      e_r = W3'(s2_re_q[k]);
      e_i = W3'(s2_im_q[k]);
      pa  = PW'(o_r) * CP;
      pb  = PW'(o_i) * CP;
      if (k == 1) begin
        p_r = inv2_q ? (pa - pb) : (pa + pb);
        p_i = inv2_q ? (pa + pb) : (pb - pa);
      end else begin
        p_r = inv2_q ? (-pa - pb) : (pb - pa);
        p_i = inv2_q ? (pa - pb)  : (-pa - pb);
      end
      case (k)
        0: begin
          t_r = W3'(o_r);
          t_i = W3'(o_i);
        end
        2: begin
          t_r = inv2_q ? -W3'(o_i) :  W3'(o_i);
          t_i = inv2_q ?  W3'(o_r) : -W3'(o_r);
        end
        default: begin
          t_r = W3'((p_r + RND) >>> (TW_W - 1));
          t_i = W3'((p_i + RND) >>> (TW_W - 1));
        end
      endcase
      c = clamp(half3(e_r + t_r));
      re_d[k*OUT_W +: OUT_W] = c[OUT_W-1:0];
      ovf_d = ovf_d | c[OUT_W];
      c = clamp(half3(e_i + t_i));
      im_d[k*OUT_W +: OUT_W] = c[OUT_W-1:0];
      ovf_d = ovf_d | c[OUT_W];
      c = clamp(half3(e_r - t_r));
      re_d[(k+4)*OUT_W +: OUT_W] = c[OUT_W-1:0];
      ovf_d = ovf_d | c[OUT_W];
      c = clamp(half3(e_i - t_i));
      im_d[(k+4)*OUT_W +: OUT_W] = c[OUT_W-1:0];
      ovf_d = ovf_d | c[OUT_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      inv1_q  <= 1'b0;
      inv2_q  <= 1'b0;
      inv3_q  <= 1'b0;
      ovf_q   <= 1'b0;
      s1_re_q <= '{default: '0};
      s1_im_q <= '{default: '0};
      s2_re_q <= '{default: '0};
      s2_im_q <= '{default: '0};
      re_q    <= '0;
      im_q    <= '0;
    end else if (adv) begin
      v1_q    <= s_valid;
      v2_q    <= v1_q;
      v3_q    <= v2_q;
      inv1_q  <= s_inverse;
      inv2_q  <= inv1_q;
      inv3_q  <= inv2_q;
      ovf_q   <= ovf_d;
      s1_re_q <= s1_re_d;
      s1_im_q <= s1_im_d;
      s2_re_q <= s2_re_d;
      s2_im_q <= s2_im_d;
      re_q    <= re_d;
      im_q    <= im_d;
    end
  end
endmodule

// File: tb/tb_fft8_stream_cplx.sv
// Scoreboard bench for fft8_stream_cplx: default, halving (SCALE=1) and narrow-output
// (OUT_W=10) instances share one input stream and are compared against an in-place DIT model.
`timescale 1ns/1ps
module tb_fft8_stream_cplx;
  logic         clk;
  logic         reset_n, s_valid, s_inverse, m_ready;
  logic [63:0]  s_re, s_im;
  logic         rdy0, rdy1, rdy2, mv0, mv1, mv2, inv0, inv1, inv2, ovf0, ovf1, ovf2;
  logic [127:0] re0, im0, re1, im1;
  logic [79:0]  re2, im2;

  typedef struct {
    logic [127:0] re0, im0, re1, im1, re2, im2;
    logic         ovf0, ovf1, ovf2, inv;
  } exp_t;

  exp_t        sb[$];
  int          cmp_cnt, err_cnt, stall_left;
  bit          rand_ready, accepted;
  logic [2:0]  vq;
  logic [63:0] f_re, f_im;

  fft8_stream_cplx u_dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(rdy0), .s_inverse(s_inverse),
    .s_re(s_re), .s_im(s_im), .m_valid(mv0), .m_ready(m_ready), .m_inverse(inv0),
    .m_ovf(ovf0), .m_re(re0), .m_im(im0));

  fft8_stream_cplx #(.SCALE(1)) u_scl (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(rdy1), .s_inverse(s_inverse),
    .s_re(s_re), .s_im(s_im), .m_valid(mv1), .m_ready(m_ready), .m_inverse(inv1),
    .m_ovf(ovf1), .m_re(re1), .m_im(im1));

  fft8_stream_cplx #(.OUT_W(10)) u_sat (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(rdy2), .s_inverse(s_inverse),
    .s_re(s_re), .s_im(s_im), .m_valid(mv2), .m_ready(m_ready), .m_inverse(inv2),
    .m_ovf(ovf2), .m_re(re2), .m_im(im2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int rnd(input int x);
    return int'((longint'(x) * 23170 + 64'sd16384) >>> 15);
  endfunction

  function automatic int halve(input int v, input bit scl);
    return scl ? (v >>> 1) : v;
  endfunction

  function automatic void model(input logic [63:0] xre, input logic [63:0] xim, input bit inv,
                                input bit scl, input int ow, output logic [127:0] ore,
                                output logic [127:0] oim, output logic ovf);
    int vr[8], vi[8];
    int ar, ai, tr, ti, cr, ci, tw, r, lim, v;
    logic [31:0] bits;
    ore = '0;
    oim = '0;
    ovf = 1'b0;
    lim = 1 << (ow - 1);
    for (int n = 0; n < 8; n++) begin
      r = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
      vr[n] = int'($signed(xre[r*8 +: 8]));
      vi[n] = int'($signed(xim[r*8 +: 8]));
    end
    for (int span = 1; span < 8; span = span * 2) begin
      for (int base = 0; base < 8; base = base + 2 * span) begin
        for (int j = 0; j < span; j++) begin
          tw = j * (4 / span);
          case (tw)
            0:       begin cr = 1;  ci = 0;  end
            1:       begin cr = 1;  ci = -1; end
            2:       begin cr = 0;  ci = -1; end
            default: begin cr = -1; ci = -1; end
          endcase
          if (inv) ci = -ci;
          ar = vr[base+j+span];
          ai = vi[base+j+span];
          tr = ar * cr - ai * ci;
          ti = ar * ci + ai * cr;
          if (cr != 0 && ci != 0) begin
            tr = rnd(tr);
            ti = rnd(ti);
          end
          ar = vr[base+j];
          ai = vi[base+j];
          vr[base+j]      = halve(ar + tr, scl);
          vi[base+j]      = halve(ai + ti, scl);
          vr[base+j+span] = halve(ar - tr, scl);
          vi[base+j+span] = halve(ai - ti, scl);
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 8; k++) begin
        v = (p == 0) ? vr[k] : vi[k];
        if (v > lim - 1) begin
          v = lim - 1;
          ovf = 1'b1;
        end else if (v < -lim) begin
          v = -lim;
          ovf = 1'b1;
        end
        bits = v;
        for (int b = 0; b < ow; b++) begin
          if (p == 0) ore[k*ow+b] = bits[b];
          else        oim[k*ow+b] = bits[b];
        end
      end
    end
  endfunction

  task automatic predict(output exp_t e);
    model(s_re, s_im, s_inverse, 1'b0, 16, e.re0, e.im0, e.ovf0);
    model(s_re, s_im, s_inverse, 1'b1, 16, e.re1, e.im1, e.ovf1);
    model(s_re, s_im, s_inverse, 1'b0, 10, e.re2, e.im2, e.ovf2);
    e.inv = s_inverse;
  endtask

  // One clock: drive m_ready, check handshake/outputs mid-cycle, then advance the occupancy model.
  task automatic step();
    exp_t e;
    logic adv;
    m_ready = (stall_left > 0) ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    if (stall_left > 0) stall_left--;
    #1;
    adv = !vq[2] || m_ready;
    check("s_ready", 128'({rdy0, rdy1, rdy2}), 128'({3{adv}}));
    check("m_valid", 128'({mv0, mv1, mv2}), 128'({3{vq[2]}}));
    if (vq[2] && sb.size() != 0) begin
      e = sb[0];
      check("re_base", re0, e.re0);
      check("im_base", im0, e.im0);
      check("re_scale", re1, e.re1);
      check("im_scale", im1, e.im1);
      check("re_sat", 128'(re2), e.re2);
      check("im_sat", 128'(im2), e.im2);
      check("ovf", 128'({ovf0, ovf1, ovf2}), 128'({e.ovf0, e.ovf1, e.ovf2}));
      check("m_inverse", 128'({inv0, inv1, inv2}), 128'({3{e.inv}}));
      if (m_ready) void'(sb.pop_front());
    end
    accepted = s_valid && adv;
    if (accepted) begin
      predict(e);
      sb.push_back(e);
    end
    @(posedge clk);
    if (adv) vq = {vq[1:0], s_valid};
    @(negedge clk);
  endtask

  task automatic send(input logic [63:0] re, input logic [63:0] im, input bit inv);
    int guard;
    s_valid   = 1'b1;
    s_re      = re;
    s_im      = im;
    s_inverse = inv;
    accepted  = 1'b0;
    guard     = 0;
    while (!accepted && guard < 50) begin
      step();
      guard++;
    end
    check("send_accept", 128'(accepted), 128'(1));
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic drain();
    int guard;
    s_valid = 1'b0;
    guard   = 0;
    while (sb.size() != 0 && guard < 100) begin
      step();
      guard++;
    end
    check("drain_empty", 128'(sb.size()), 128'(0));
    idle(2);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_flags"}, 128'({mv0, mv1, mv2, ovf0, ovf1, ovf2, inv0, inv1, inv2}), 128'(0));
    check({tag, "_base"}, re0 | im0, 128'(0));
    check({tag, "_scale"}, re1 | im1, 128'(0));
    check({tag, "_sat"}, 128'(re2 | im2), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmp_cnt = 0; err_cnt = 0; stall_left = 0; rand_ready = 1'b0; accepted = 1'b0; vq = '0;
    reset_n = 1'b0; s_valid = 1'b0; s_inverse = 1'b0; s_re = '0; s_im = '0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset_n = 1'b1;

    // impulse, DC, forward/inverse single tone
    f_re = 64'h1;            f_im = '0; send(f_re, f_im, 1'b0); idle(5);
    f_re = {8{8'd10}};       send(f_re, f_im, 1'b0); drain();
    f_re = 64'h6400;         send(f_re, f_im, 1'b0); send(f_re, f_im, 1'b1); drain();

    // backpressure: four back-to-back frames against a 5-cycle stall
    stall_left = 5;
    for (int i = 0; i < 4; i++) begin
      f_re = {$urandom, $urandom};
      f_im = {$urandom, $urandom};
      send(f_re, f_im, i[0]);
    end
    drain();

    // saturation on the narrow instance, then a small frame right behind it
    f_re = {8{8'h80}}; f_im = '0; send(f_re, f_im, 1'b0);
    f_re = {8{8'h01}};            send(f_re, f_im, 1'b0);
    drain();

    // asynchronous reset with three frames in flight
    stall_left = 100;
    for (int i = 0; i < 3; i++) begin
      f_re = {$urandom, $urandom};
      f_im = {$urandom, $urandom};
      send(f_re, f_im, 1'b0);
    end
    #1 reset_n = 1'b0;
    #1 check_idle("rst_flight");
    sb.delete();
    vq = '0;
    stall_left = 0;
    #1 reset_n = 1'b1;
    idle(5);
    f_re = 64'h1; f_im = 64'h100; send(f_re, f_im, 1'b1); drain();

    // random traffic with random gaps and random m_ready
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else begin
        f_re = {$urandom, $urandom};
        f_im = {$urandom, $urandom};
        send(f_re, f_im, 1'($urandom_range(0, 1)));
      end
    end
    rand_ready = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
